hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Drives the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.
- Handles load-use interlock, taken-branch flush, multi-cycle mult/div busy, and data-memory wait.
- Its `id_ex_ctrl` output is the bubble-insert control of the ID/EX register.

Parameters:
- MD_LATENCY, 32: cycles a mult/div occupies EX, counting the issue cycle; legal range 2..255.
- CNT_W, 8: width of the mult/div down-counter.

Ports:
- clk  in  1  system clock; state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- Rs_id  in  5  source register Rs of the instruction in ID.
- Rt_id  in  5  source register Rt of the instruction in ID.
- uses_rt_id  in  1  ID instruction reads Rt (R-type, store, beq/bne).
- Rt_ex  in  5  destination register of the instruction in EX.
- MemtoReg_ex  in  1  EX instruction is a load.
- RegWr_ex  in  1  EX instruction writes the register file.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- md_start  in  1  mult/div instruction in EX this cycle.
- mem_wait  in  1  data memory not ready in MEM this cycle.
- pc_wr  out  1  PC update enable.
- if_id_wr  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID clear to NOP.
- id_ex_ctrl  out  1  ID/EX bubble insert; clears control bits [99:90].
- id_ex_hold  out  1  ID/EX holds its current contents.
- ex_mem_hold  out  1  EX/MEM holds its current contents.
- md_busy  out  1  mult/div unit occupied.

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- State register: RUN, MD_BUSY, MEM_WAIT. Counter `md_cnt[CNT_W-1:0]`.
- Reset: state=RUN, md_cnt=0. Output values during and after reset:
  - pc_wr=1, if_id_wr=1.
  - if_id_flush=0, id_ex_ctrl=0, id_ex_hold=0, ex_mem_hold=0, md_busy=0.
- Outputs are combinational from state and current inputs, valid before the pipeline-register edge.
- Priority within a cycle, highest first: mem_wait > MD_BUSY > branch_taken > md_start > load-use.
- mem_wait=1, any state:
  - Outputs: pc_wr=0, if_id_wr=0, id_ex_hold=1, ex_mem_hold=1, id_ex_ctrl=0, if_id_flush=0.
  - Next state MEM_WAIT; the previous state is saved.
  - md_cnt is frozen.
  - When mem_wait drops, return to the saved state.
- MD_BUSY, with mem_wait=0:
  - Outputs: pc_wr=0, if_id_wr=0, id_ex_hold=1, md_busy=1.
  - md_cnt decrements each cycle.
  - When md_cnt==0, next state is RUN; that final cycle still stalls.
- RUN, branch_taken=1:
  - Outputs: if_id_flush=1, id_ex_ctrl=1, pc_wr=1 (target loads).
  - Load-use and md_start are ignored, since the EX instruction is the branch.
- RUN, md_start=1, no branch:
  - md_cnt <= MD_LATENCY-2; next state MD_BUSY.
  - The issue cycle itself also stalls: pc_wr=0, if_id_wr=0, id_ex_hold=1, md_busy=1.
  - Total stall is MD_LATENCY cycles.
- RUN, load-use:
  - Condition: MemtoReg_ex & RegWr_ex & (Rt_ex!=0) & ((Rt_ex==Rs_id) | (uses_rt_id & Rt_ex==Rt_id)).
  - Outputs: pc_wr=0, if_id_wr=0, id_ex_ctrl=1; one-cycle bubble.
  - The bubble clears MemtoReg in EX the next cycle, so there is no retrigger.
- Register $0 never causes a hazard.
- id_ex_ctrl and id_ex_hold are never both 1. When both would be requested, hold wins.
- rst asserted mid-MD_BUSY or mid-MEM_WAIT aborts immediately to RUN; md_cnt=0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs `stall_cycles[31:0]` and `flush_count[15:0]`.
  - stall_cycles increments every cycle pc_wr=0.
  - flush_count increments on each if_id_flush.
  - Both counters saturate at all-ones and clear on rst.
- Without it: no counters and no extra ports.

Decomposition:
- Shared package `hazard_pkg`:
  - State enum: RUN=2'd0, MD_BUSY=2'd1, MEM_WAIT=2'd2.
  - REG_ZERO=5'd0.
  - Default MD_LATENCY.
- Sub-module `load_use_detect` is natural: purely combinational comparator producing the load-use hit.
- FSM and counter stay in the top module.

Test Plan:
- Load-use: Rt_ex=5, MemtoReg_ex=1, RegWr_ex=1, Rs_id=5 -> exactly one cycle with pc_wr=0, if_id_wr=0, id_ex_ctrl=1. Repeat with Rt_ex=0 -> no stall.
- Branch flush: branch_taken=1 in RUN together with a load-use match -> if_id_flush=1, id_ex_ctrl=1, pc_wr=1; no stall.
- Mult/div: md_start=1 with MD_LATENCY=4 -> md_busy=1 and pc_wr=0 for exactly 4 cycles, then RUN with pc_wr=1.
- Memory wait inside MD_BUSY: mem_wait=1 for 3 cycles starting at md_cnt=1 -> counter frozen, ex_mem_hold=1. After release, 2 more busy cycles, then RUN.
- Reset mid-MD_BUSY: rst=1 for 1 cycle at md_cnt=10 -> next cycle state RUN, md_busy=0, pc_wr=1.
- HAZARD_PERF_CNT_EN: 3 load-use stalls + 2 flushes -> stall_cycles=3, flush_count=2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / stall controller.
package hazard_pkg;

    // Controller state. MEM_WAIT is transparent: on release the FSM
    // resumes whatever state it was in when the memory stall began.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Register $0 is hard-wired to zero and never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default mult/div occupancy of EX, counting the issue cycle.
    localparam int MD_LATENCY_DEF = 32;

    // Default width of the mult/div down-counter.
    localparam int CNT_W_DEF = 8;

    // Pipeline control bundle produced each cycle by the controller.
    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic if_id_flush;
        logic id_ex_ctrl;
        logic id_ex_hold;
        logic ex_mem_hold;
        logic md_busy;
    } ctrl_t;

    // Free-running pipeline: PC and IF/ID advance, nothing held or flushed.
    localparam ctrl_t CTRL_RUN = '{
        pc_wr:       1'b1,
        if_id_wr:    1'b1,
        if_id_flush: 1'b0,
        id_ex_ctrl:  1'b0,
        id_ex_hold:  1'b0,
        ex_mem_hold: 1'b0,
        md_busy:     1'b0
    };

endpackage : hazard_pkg

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Purely combinational.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] Rs_id,
    input  logic [4:0] Rt_id,
    input  logic       uses_rt_id,
    input  logic [4:0] Rt_ex,
    input  logic       MemtoReg_ex,
    input  logic       RegWr_ex,
    output logic       hit
);

    logic ex_is_load_wr;
    logic rs_match;
    logic rt_match;

    // A load that really writes a non-zero register is a potential producer.
    assign ex_is_load_wr = MemtoReg_ex & RegWr_ex & (Rt_ex != REG_ZERO);

    // Rs is always read; Rt only matters when the ID instruction consumes it.
    assign rs_match = (Rt_ex == Rs_id);
    assign rt_match = uses_rt_id & (Rt_ex == Rt_id);

    assign hit = ex_is_load_wr & (rs_match | rt_match);

endmodule : load_use_detect

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS core.
// Drives PC, IF/ID, ID/EX and EX/MEM enables for load-use interlock,
// taken-branch flush, multi-cycle mult/div and data-memory wait.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = CNT_W_DEF
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs_id,
    input  logic [4:0] Rt_id,
    input  logic       uses_rt_id,
    input  logic [4:0] Rt_ex,
    input  logic       MemtoReg_ex,
    input  logic       RegWr_ex,
    input  logic       branch_taken,
    input  logic       md_start,
    input  logic       mem_wait,
    output logic       pc_wr,
    output logic       if_id_wr,
    output logic       if_id_flush,
    output logic       id_ex_ctrl,
    output logic       id_ex_hold,
    output logic       ex_mem_hold,
    output logic       md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    // The issue cycle stalls too, so the counter covers the remaining
    // MD_LATENCY-1 cycles, ending on the cycle where it reads zero.
    localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_LATENCY - 2);

    state_t           state;
    state_t           state_nxt;
    state_t           saved_state;
    state_t           saved_nxt;
    state_t           eff_state;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lu_hit;
    ctrl_t            ctrl;

    load_use_detect u_load_use_detect (
        .Rs_id       (Rs_id),
        .Rt_id       (Rt_id),
        .uses_rt_id  (uses_rt_id),
        .Rt_ex       (Rt_ex),
        .MemtoReg_ex (MemtoReg_ex),
        .RegWr_ex    (RegWr_ex),
        .hit         (lu_hit)
    );

    // Once mem_wait drops, MEM_WAIT behaves exactly like the saved state,
    // so the release cycle already does useful work.
    assign eff_state = (state == MEM_WAIT) ? saved_state : state;

    // State register: FSM state, pre-stall state and mult/div counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state       <= RUN;
            saved_state <= RUN;
            md_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            saved_state <= saved_nxt;
            md_cnt      <= cnt_nxt;
        end
    end

    // Next-state logic: memory wait freezes everything, otherwise the
    // effective state decides between running, issuing and counting down.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no
        // latch is inferred.
        state_nxt = eff_state;
        saved_nxt = saved_state;
        cnt_nxt   = md_cnt;

        if (mem_wait) begin
            state_nxt = MEM_WAIT;
            saved_nxt = eff_state;
        end else begin
            unique case (eff_state)
                MD_BUSY: begin
                    if (md_cnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = md_cnt - 1'b1;
                    end
                end
                RUN: begin
                    // A taken branch owns EX, so a concurrent md_start is
                    // not a real mult/div and must not issue.
                    if (!branch_taken && md_start) begin
                        state_nxt = MD_BUSY;
                        cnt_nxt   = MD_RELOAD;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // Output logic: prioritised stall/flush requests for the current cycle.
    always_comb begin
        ctrl = CTRL_RUN;

        if (rst) begin
            ctrl = CTRL_RUN;
        end else if (mem_wait) begin
            // Freeze the whole front end and EX/MEM until memory responds;
            // an in-flight mult/div still occupies its unit.
            ctrl.pc_wr       = 1'b0;
            ctrl.if_id_wr    = 1'b0;
            ctrl.id_ex_hold  = 1'b1;
            ctrl.ex_mem_hold = 1'b1;
            ctrl.md_busy     = (eff_state == MD_BUSY);
        end else begin
            unique case (eff_state)
                MD_BUSY: begin
                    ctrl.pc_wr      = 1'b0;
                    ctrl.if_id_wr   = 1'b0;
                    ctrl.id_ex_hold = 1'b1;
                    ctrl.md_busy    = 1'b1;
                end
                RUN: begin
                    if (branch_taken) begin
                        // Squash the two younger instructions; target loads.
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_ctrl  = 1'b1;
                    end else if (md_start) begin
                        ctrl.pc_wr      = 1'b0;
                        ctrl.if_id_wr   = 1'b0;
                        ctrl.id_ex_hold = 1'b1;
                        ctrl.md_busy    = 1'b1;
                    end else if (lu_hit) begin
                        // One bubble; it clears MemtoReg in EX so the
                        // hazard does not retrigger next cycle.
                        ctrl.pc_wr      = 1'b0;
                        ctrl.if_id_wr   = 1'b0;
                        ctrl.id_ex_ctrl = 1'b1;
                    end
                end
                default: begin
                    ctrl = CTRL_RUN;
                end
            endcase
        end
    end

    assign pc_wr       = ctrl.pc_wr;
    assign if_id_wr    = ctrl.if_id_wr;
    assign if_id_flush = ctrl.if_id_flush;
    // Holding ID/EX and bubbling it are contradictory; hold wins.
    assign id_ex_ctrl  = ctrl.id_ex_ctrl & ~ctrl.id_ex_hold;
    assign id_ex_hold  = ctrl.id_ex_hold;
    assign ex_mem_hold = ctrl.ex_mem_hold;
    assign md_busy     = ctrl.md_busy;

`ifdef HAZARD_PERF_CNT_EN
    // Saturating stall-cycle and flush event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_wr && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (if_id_flush && (flush_count != '1)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl with a scoreboard of
// expected control vectors. Perf counter checks compile with HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    localparam int LAT = 12;

    // Expected vectors, bit order {pc_wr,if_id_wr,if_id_flush,id_ex_ctrl,
    // id_ex_hold,ex_mem_hold,md_busy}.
    localparam logic [6:0] RUN_O = 7'b1100000;
    localparam logic [6:0] LU_O  = 7'b0001000;
    localparam logic [6:0] BR_O  = 7'b1111000;
    localparam logic [6:0] MD_O  = 7'b0000101;
    localparam logic [6:0] MW_O  = 7'b0000110;
    localparam logic [6:0] ALL   = 7'b1111111;
    localparam logic [6:0] NOBSY = 7'b1111110;

    typedef struct {
        logic [6:0] val;
        logic [6:0] mask;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs_id, Rt_id, Rt_ex;
    logic       uses_rt_id, MemtoReg_ex, RegWr_ex;
    logic       branch_taken, md_start, mem_wait;
    logic       pc_wr, if_id_wr, if_id_flush, id_ex_ctrl;
    logic       id_ex_hold, ex_mem_hold, md_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .Rs_id        (Rs_id),
        .Rt_id        (Rt_id),
        .uses_rt_id   (uses_rt_id),
        .Rt_ex        (Rt_ex),
        .MemtoReg_ex  (MemtoReg_ex),
        .RegWr_ex     (RegWr_ex),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .mem_wait     (mem_wait),
        .pc_wr        (pc_wr),
        .if_id_wr     (if_id_wr),
        .if_id_flush  (if_id_flush),
        .id_ex_ctrl   (id_ex_ctrl),
        .id_ex_hold   (id_ex_hold),
        .ex_mem_hold  (ex_mem_hold),
        .md_busy      (md_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    task automatic clear_inputs();
        Rs_id = 5'd0; Rt_id = 5'd0; uses_rt_id = 1'b0; Rt_ex = 5'd0;
        MemtoReg_ex = 1'b0; RegWr_ex = 1'b0;
        branch_taken = 1'b0; md_start = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rs, input logic [4:0] rt,
                            input logic urt, input logic [4:0] rtex,
                            input logic wr);
        Rs_id = rs; Rt_id = rt; uses_rt_id = urt; Rt_ex = rtex;
        MemtoReg_ex = 1'b1; RegWr_ex = wr;
    endtask

    // Compare the oldest scoreboard entry with the live outputs.
    task automatic check_out();
        exp_t       x;
        logic [6:0] obs;
        x   = sb.pop_front();
        obs = {pc_wr, if_id_wr, if_id_flush, id_ex_ctrl, id_ex_hold, ex_mem_hold, md_busy};
        n_checks++;
        assert ((obs & x.mask) === (x.val & x.mask))
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (mask %b)", x.tag, obs, x.val, x.mask);
        end
    endtask

    // Inputs are already driven; record expectation, check mid-cycle, then
    // let the edge commit and move 1 time unit past it.
    task automatic step(input logic [6:0] e, input logic [6:0] m, input string tag);
        exp_t x;
        x.val = e; x.mask = m; x.tag = tag;
        sb.push_back(x);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with a load-use pattern present: outputs must stay at RUN values.
        clear_inputs();
        rst = 1'b1;
        set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        step(RUN_O, ALL, "reset_outputs");
        step(RUN_O, ALL, "reset_outputs_2");
        rst = 1'b0;
        clear_inputs();
        step(RUN_O, ALL, "idle_after_reset");

        // Three load-use stalls, each a single bubble.
        for (int i = 0; i < 3; i++) begin
            set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
            step(LU_O, ALL, "load_use");
            clear_inputs();
            step(RUN_O, ALL, "after_bubble");
        end

        // Taken branch beats load-use and md_start.
        set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        branch_taken = 1'b1;
        step(BR_O, ALL, "branch_over_lu");
        clear_inputs();
        step(RUN_O, ALL, "after_branch");
        branch_taken = 1'b1;
        md_start     = 1'b1;
        step(BR_O, ALL, "branch_over_md");
        clear_inputs();
        step(RUN_O, ALL, "no_md_after_branch");

`ifdef HAZARD_PERF_CNT_EN
        check_val("stall_cycles", stall_cycles, 32'd3);
        check_val("flush_count", {16'd0, flush_count}, 32'd2);
`endif

        // Load-use boundary conditions.
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step(RUN_O, ALL, "reg_zero_no_hazard");
        set_load(5'd3, 5'd7, 1'b0, 5'd7, 1'b1);
        step(RUN_O, ALL, "rt_not_used");
        set_load(5'd3, 5'd7, 1'b1, 5'd7, 1'b1);
        step(LU_O, ALL, "rt_match");
        set_load(5'd7, 5'd0, 1'b0, 5'd7, 1'b0);
        step(RUN_O, ALL, "no_regwr");
        clear_inputs();
        step(RUN_O, ALL, "idle");

        // Mult/div: LAT stall cycles, MD_BUSY ignores branch and load-use.
        md_start = 1'b1;
        step(MD_O, ALL, "md_issue");
        clear_inputs();
        for (int i = 1; i < LAT; i++) begin
            if (i == 3) begin
                set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
                branch_taken = 1'b1;
            end
            step(MD_O, ALL, "md_busy");
            clear_inputs();
        end
        step(RUN_O, ALL, "md_done");

        // Memory wait arriving when md_cnt==1: counter frozen for 3 cycles.
        md_start = 1'b1;
        step(MD_O, ALL, "md_issue_2");
        clear_inputs();
        for (int i = 0; i < LAT - 3; i++) begin
            step(MD_O, ALL, "md_busy_2");
        end
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(MW_O, NOBSY, "mw_in_md");
        end
        mem_wait = 1'b0;
        step(MD_O, ALL, "md_after_mw_1");
        step(MD_O, ALL, "md_after_mw_2");
        step(RUN_O, ALL, "run_after_mw");

        // Memory wait in RUN overrides load-use; release resumes RUN.
        set_load(5'd9, 5'd0, 1'b0, 5'd9, 1'b1);
        mem_wait = 1'b1;
        step(MW_O, NOBSY, "mw_in_run");
        step(MW_O, NOBSY, "mw_in_run_2");
        mem_wait = 1'b0;
        step(LU_O, ALL, "lu_after_mw");
        clear_inputs();
        step(RUN_O, ALL, "idle_2");

        // Reset mid-MD_BUSY at md_cnt==LAT-2.
        md_start = 1'b1;
        step(MD_O, ALL, "md_issue_3");
        clear_inputs();
        rst = 1'b1;
        step(RUN_O, ALL, "reset_mid_md");
        rst = 1'b0;
        step(RUN_O, ALL, "run_after_rst_md");

        // Reset mid-MEM_WAIT while a mult/div was pending.
        md_start = 1'b1;
        step(MD_O, ALL, "md_issue_4");
        clear_inputs();
        mem_wait = 1'b1;
        step(MW_O, NOBSY, "mw_before_rst");
        mem_wait = 1'b0;
        rst = 1'b1;
        step(RUN_O, ALL, "reset_mid_mw");
        rst = 1'b0;
        step(RUN_O, ALL, "run_after_rst_mw");

`ifdef HAZARD_PERF_CNT_EN
        check_val("stall_cycles_cleared", stall_cycles, 32'd0);
        check_val("flush_count_cleared", {16'd0, flush_count}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
